// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: default sizing and beat layout.
package axis_pkg;

  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_DEPTH  = 16;

  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port beat storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module axis_fifo_mem #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the beat at the write index on the rising edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Packet-aware AXI-Stream FIFO. Beats are held back until a complete packet is
// stored (store-and-forward); a packet larger than the buffer switches to
// cut-through until its last beat leaves, so it cannot deadlock the FIFO.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = AXIS_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   cut_through
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_level;
  logic [PW-1:0]     r_pkt_count;
  logic              r_cut;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [DATA_W:0]   w_wdata;
  logic [DATA_W:0]   w_rdata;

  // Pointer MSB is the wrap bit: equal indexes with differing wrap bits means full.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Ready never depends on a same-cycle read; a slot freed while full is offered next cycle.
  assign s_ready   = !rst && !w_full;
  assign m_valid   = !rst && !w_empty && ((r_pkt_count != '0) || r_cut);

  assign w_wr      = s_valid && s_ready;
  assign w_rd      = m_valid && m_ready;
  assign w_wr_last = w_wr && s_last;
  assign w_rd_last = w_rd && m_last;

  assign w_wdata   = {s_last, s_data};
  assign m_last    = w_rdata[DATA_W];
  assign m_data    = w_rdata[DATA_W-1:0];

  assign level       = r_level;
  assign pkt_count   = r_pkt_count;
  assign cut_through = r_cut;

  axis_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Pointers and beat level: advance on handshakes only; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Complete-packet count: a last beat in adds one, a last beat out removes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_wr_last, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Cut-through: entered when the buffer is full of a single unfinished packet,
  // left when that packet's last beat is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cut <= 1'b0;
    end else if (w_full && (r_pkt_count == '0)) begin
      r_cut <= 1'b1;
    end else if (w_rd_last) begin
      r_cut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: directed scenarios plus random traffic, all compared
// every cycle against a queue-based packet FIFO model.
module tb_axis_pkt_fifo;
  import axis_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic [4:0]    level;
  logic [4:0]    pkt_count;
  logic          cut_through;

  int checks = 0;
  int errors = 0;

  // Model state: stored beats, complete packets, cut-through flag.
  axis_beat_t q[$];
  int         m_pkts = 0;
  bit         m_cut  = 0;

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .level       (level),
    .pkt_count   (pkt_count),
    .cut_through (cut_through)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare against the model, clock, update model.
  task automatic step(input bit r, input bit sv, input int sd, input bit sl, input bit mr);
    bit         e_srdy;
    bit         e_mvld;
    bit         wr;
    bit         rd;
    bit         rd_last;
    bit         set_cut;
    axis_beat_t b;
    rst     = r;
    s_valid = sv;
    s_data  = sd[DW-1:0];
    s_last  = sl;
    m_ready = mr;
    #1;
    e_srdy = !r && (q.size() != DP);
    e_mvld = !r && (q.size() != 0) && (m_pkts != 0 || m_cut);
    chk("s_ready", int'(s_ready), int'(e_srdy));
    chk("m_valid", int'(m_valid), int'(e_mvld));
    if (!r) begin
      chk("level", int'(level), q.size());
      chk("pkt_count", int'(pkt_count), m_pkts);
      chk("cut_through", int'(cut_through), int'(m_cut));
    end
    if (e_mvld) begin
      chk("m_data", int'(m_data), int'(q[0].data));
      chk("m_last", int'(m_last), int'(q[0].last));
    end
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_pkts = 0;
      m_cut  = 0;
    end else begin
      wr      = sv && e_srdy;
      rd      = e_mvld && mr;
      rd_last = rd && q[0].last;
      set_cut = (q.size() == DP) && (m_pkts == 0);
      if (rd) void'(q.pop_front());
      if (wr) begin
        b.last = sl;
        b.data = sd[DW-1:0];
        q.push_back(b);
      end
      m_pkts = m_pkts + int'(wr && sl) - int'(rd_last);
      if (set_cut) m_cut = 1;
      else if (rd_last) m_cut = 0;
    end
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, mr);
  endtask

  initial begin
    rst = 1; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_pkt_count", int'(pkt_count), 0);

    // Three-beat packet held until its last beat, then streamed
    step(0, 1, 8'h11, 0, 1);
    step(0, 1, 8'h22, 0, 1);
    step(0, 1, 8'h33, 1, 1);
    #1;
    chk("p3_pkt_count", int'(pkt_count), 1);
    chk("p3_first_data", int'(m_data), 8'h11);
    idle(4, 1);
    chk("p3_level_end", int'(level), 0);

    // Single-beat packet visible one cycle after its write
    step(0, 1, 8'hA5, 1, 0);
    #1;
    chk("one_m_valid", int'(m_valid), 1);
    chk("one_m_data", int'(m_data), 8'hA5);
    chk("one_m_last", int'(m_last), 1);
    idle(2, 1);

    // Oversize packet: fill without last, cut-through engages
    for (int i = 0; i < 16; i++) step(0, 1, 8'h40 + i, 0, 0);
    idle(1, 0);
    chk("big_level", int'(level), 16);
    chk("big_cut", int'(cut_through), 1);
    chk("big_s_ready", int'(s_ready), 0);
    chk("big_m_valid", int'(m_valid), 1);
    idle(16, 1);
    step(0, 1, 8'h5F, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("big_cut_clear", int'(cut_through), 0);
    idle(2, 1);

    // Simultaneous last-read and last-write keep pkt_count and level
    step(0, 1, 8'h61, 0, 0);
    step(0, 1, 8'h62, 1, 0);
    step(0, 1, 8'h71, 0, 0);
    step(0, 1, 8'h72, 1, 0);
    step(0, 1, 8'h81, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("sim_pre_pkts", int'(pkt_count), 2);
    chk("sim_pre_level", int'(level), 4);
    step(0, 1, 8'h82, 1, 1);
    chk("sim_pkts", int'(pkt_count), 2);
    chk("sim_level", int'(level), 4);
    idle(8, 1);

    // Downstream stall: head beat must hold
    step(0, 1, 8'h91, 0, 0);
    step(0, 1, 8'h92, 1, 0);
    idle(5, 0);
    chk("stall_data", int'(m_data), 8'h91);
    idle(4, 1);

    // Reset in the middle of a packet
    step(0, 1, 8'hB1, 0, 0);
    step(0, 1, 8'hB2, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_pkts", int'(pkt_count), 0);
    chk("mid_rst_m_valid", int'(m_valid), 0);
    step(0, 1, 8'hC3, 1, 0);
    chk("after_rst_data", int'(m_data), 8'hC3);
    idle(3, 1);

    // Random traffic with alternating short and long packet phases
    for (int c = 0; c < 4000; c++) begin
      int lastp;
      lastp = ((c / 500) % 2) ? 40 : 3;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)),
           $urandom_range(0, lastp - 1) == 0,
           $urandom_range(0, 2) != 0);
    end
    idle(40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
